// File: rtl/scan_chain_controller_if.sv
// Host/chain signal bundle for scan_chain_controller.
// The slave modport is the controller's view; master is the host plus chain side.
interface scan_chain_controller_if #(
    parameter int unsigned CHAIN_LEN = 4
);
    logic                 i_start;
    logic                 i_abort;
    logic [CHAIN_LEN-1:0] i_pattern;
    logic                 i_TDO;
    logic                 o_TST;
    logic                 o_TDI;
    logic                 o_busy;
    logic                 o_done;
    logic [CHAIN_LEN-1:0] o_capture;
    logic                 o_parity;

    modport master (
        output i_start, i_abort, i_pattern, i_TDO,
        input  o_TST, o_TDI, o_busy, o_done, o_capture, o_parity
    );

    modport slave (
        input  i_start, i_abort, i_pattern, i_TDO,
        output o_TST, o_TDI, o_busy, o_done, o_capture, o_parity
    );
endinterface

// File: rtl/scan_chain_controller.sv
// Scan chain sequencer: one capture of the chain's parallel inputs followed by
// CHAIN_LEN shift cycles that unload the captured word and load a new pattern.
// Optional feature: define SCAN_PARITY_EN to produce o_parity = ^o_capture.
module scan_chain_controller #(
    parameter int unsigned CHAIN_LEN = 4
) (
    input  logic                  i_TCK,
    input  logic                  i_nRESET,
    scan_chain_controller_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] sr_q;
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CHAIN_LEN-1:0] sr_shift;
    logic                 last_shift;
    logic                 cap_en;

    assign last_shift = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    // Shift register value after this cycle's TDO bit; becomes o_capture on DONE entry.
    assign sr_shift   = {sr_q[CHAIN_LEN-2:0], bus.i_TDO};
    assign cap_en     = (state_q == SHIFT) && (state_d == DONE);

    // State register
    always_ff @(posedge i_TCK or negedge i_nRESET) begin
        if (!i_nRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins only while busy, start only counts in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = CAPTURE;
            CAPTURE: state_d = bus.i_abort ? IDLE : SHIFT;
            SHIFT: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                end else if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state and pattern register only
    always_comb begin
        bus.o_TST  = 1'b0;
        bus.o_TDI  = 1'b0;
        bus.o_busy = 1'b0;
        bus.o_done = 1'b0;
        case (state_q)
            CAPTURE: bus.o_busy = 1'b1;
            SHIFT: begin
                bus.o_TST  = 1'b1;
                bus.o_TDI  = pat_q[CHAIN_LEN-1];
                bus.o_busy = 1'b1;
            end
            DONE:    bus.o_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: pattern latch/shift-out, capture shift-in, shift counter
    always_ff @(posedge i_TCK or negedge i_nRESET) begin
        if (!i_nRESET) begin
            cnt_q <= '0;
            pat_q <= '0;
            sr_q  <= '0;
        end else begin
            case (state_q)
                IDLE:    if (bus.i_start) pat_q <= bus.i_pattern;
                CAPTURE: cnt_q <= '0;
                SHIFT: begin
                    pat_q <= {pat_q[CHAIN_LEN-2:0], 1'b0};
                    sr_q  <= sr_shift;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Captured word register; untouched by aborted scans
    always_ff @(posedge i_TCK or negedge i_nRESET) begin
        if (!i_nRESET) begin
            cap_q <= '0;
        end else if (cap_en) begin
            cap_q <= sr_shift;
        end
    end

    assign bus.o_capture = cap_q;

`ifdef SCAN_PARITY_EN
    logic par_q;

    // Parity of the captured word, updated in the same cycle as o_capture
    always_ff @(posedge i_TCK or negedge i_nRESET) begin
        if (!i_nRESET) begin
            par_q <= 1'b0;
        end else if (cap_en) begin
            par_q <= ^sr_shift;
        end
    end

    assign bus.o_parity = par_q;
`else
    assign bus.o_parity = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller with CHAIN_LEN = 4 wired to a behavioural 4-bit chain.
module tb_scan_chain_controller;
    localparam int unsigned CL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    scan_chain_controller_if #(.CHAIN_LEN(CL)) bus ();

    scan_chain_controller #(.CHAIN_LEN(CL)) dut (
        .i_TCK    (clk),
        .i_nRESET (rst_n),
        .bus      (bus)
    );

    // Scannable chain: parallel load when TST = 0, shift TDI into flop 0 when TST = 1
    logic [CL-1:0] chain_in = '0;
    logic [CL-1:0] chain_q  = '0;
    always @(posedge clk) chain_q <= bus.o_TST ? {chain_q[CL-2:0], bus.o_TDI} : chain_in;
    assign bus.i_TDO = chain_q[CL-1];

    int            n_vec = 0;
    int            n_err = 0;
    logic [CL-1:0] last_cap = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {busy, done, tst, tdi} in cycle c of a scan accepted in cycle 0
    function automatic logic [3:0] exp_ctrl(input int c, input logic [CL-1:0] pat);
        if (c == 1) return 4'b1000;
        if (c >= 2 && c <= int'(CL) + 1) return {3'b101, pat[int'(CL) + 1 - c]};
        if (c == int'(CL) + 2) return 4'b0100;
        return 4'b0000;
    endfunction

    function automatic logic model_parity(input logic [CL-1:0] w);
`ifdef SCAN_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] ctrl_obs();
        return {bus.o_busy, bus.o_done, bus.o_TST, bus.o_TDI};
    endfunction

    // One full scan, checking every cycle plus the result in the DONE cycle
    task automatic do_scan(input logic [CL-1:0] in_w, input logic [CL-1:0] pat, input logic ab0);
        logic [3:0] obs;
        chain_in       = in_w;
        bus.i_pattern  = pat;
        bus.i_start    = 1'b1;
        bus.i_abort    = ab0;
        for (int c = 0; c <= int'(CL) + 3; c++) begin
            obs = ctrl_obs();
            n_vec++;
            if (obs !== exp_ctrl(c, pat)) begin
                n_err++;
                $display("FAIL scan_ctrl c=%0d got %b want %b", c, obs, exp_ctrl(c, pat));
            end
            if (c == int'(CL) + 2) begin
                n_vec++;
                if (bus.o_capture !== in_w) begin
                    n_err++;
                    $display("FAIL scan_capture got %b want %b", bus.o_capture, in_w);
                end
                n_vec++;
                if (bus.o_parity !== model_parity(in_w)) begin
                    n_err++;
                    $display("FAIL scan_parity got %b want %b", bus.o_parity, model_parity(in_w));
                end
                n_vec++;
                if (chain_q !== pat) begin
                    n_err++;
                    $display("FAIL scan_chain_load got %b want %b", chain_q, pat);
                end
            end
            step();
            bus.i_start = 1'b0;
            bus.i_abort = 1'b0;
            if (c >= 1) chain_in = CL'($urandom);
        end
        last_cap = in_w;
    endtask

    task automatic test_reset();
        logic [CL+5:0] obs;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_pattern = '0;
        #2 rst_n = 1'b0;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            obs = {ctrl_obs(), bus.o_capture, bus.o_parity, 1'b0};
            n_vec++;
            if (obs !== '0) begin
                n_err++;
                $display("FAIL reset_state k=%0d got %b want 0", k, obs);
            end
            rst_n = 1'b1;
            step();
        end
        last_cap = '0;
    endtask

    task automatic test_basic();
        do_scan(4'b1011, 4'b0110, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) do_scan(CL'($urandom), CL'($urandom), 1'b0);
    endtask

    task automatic abort_at(input int ab_cyc);
        logic [CL-1:0] prev;
        logic [CL-1:0] pat;
        logic [3:0]    obs;
        logic [3:0]    exp;
        prev          = last_cap;
        pat           = CL'($urandom);
        chain_in      = ~prev;
        bus.i_pattern = pat;
        bus.i_start   = 1'b1;
        for (int c = 0; c <= ab_cyc + 5; c++) begin
            obs = ctrl_obs();
            exp = (c <= ab_cyc) ? exp_ctrl(c, pat) : 4'b0000;
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_ctrl ab=%0d c=%0d got %b want %b", ab_cyc, c, obs, exp);
            end
            if (c == ab_cyc) bus.i_abort = 1'b1;
            step();
            bus.i_start = 1'b0;
            bus.i_abort = 1'b0;
            if (c >= 1) chain_in = CL'($urandom);
        end
        n_vec++;
        if ({bus.o_capture, bus.o_parity} !== {prev, model_parity(prev)}) begin
            n_err++;
            $display("FAIL abort_keep_capture got %b/%b want %b/%b",
                     bus.o_capture, bus.o_parity, prev, model_parity(prev));
        end
    endtask

    task automatic test_abort();
        logic [3:0] obs;
        do_scan(4'b1001, 4'b0101, 1'b0);
        abort_at(3);
        for (int k = 0; k < 4; k++) abort_at(int'($urandom_range(1, CL + 1)));
        // Abort alone in IDLE must not start anything
        bus.i_abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            obs = ctrl_obs();
            n_vec++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_idle k=%0d got %b want 0000", k, obs);
            end
        end
        bus.i_abort = 1'b0;
        // Abort together with start in IDLE: start wins
        do_scan(CL'($urandom), CL'($urandom), 1'b1);
    endtask

    task automatic test_start_busy();
        logic [CL-1:0] in_w;
        logic [CL-1:0] pat;
        logic [3:0]    obs;
        int            ndone;
        int            dcyc;
        in_w          = CL'($urandom);
        pat           = CL'($urandom);
        chain_in      = in_w;
        bus.i_pattern = pat;
        ndone         = 0;
        dcyc          = -1;
        for (int c = 0; c <= 12; c++) begin
            obs = ctrl_obs();
            if (bus.o_done === 1'b1) begin
                ndone++;
                dcyc = c;
            end
            n_vec++;
            if (obs !== exp_ctrl(c, pat)) begin
                n_err++;
                $display("FAIL busy_start_ctrl c=%0d got %b want %b", c, obs, exp_ctrl(c, pat));
            end
            bus.i_start = (c == 0 || c == 3);
            step();
            bus.i_start = 1'b0;
            if (c >= 1) chain_in = CL'($urandom);
        end
        n_vec++;
        if (ndone != 1 || dcyc != int'(CL) + 2) begin
            n_err++;
            $display("FAIL busy_start_done count=%0d cycle=%0d want 1 at %0d", ndone, dcyc, CL + 2);
        end
        n_vec++;
        if (bus.o_capture !== in_w) begin
            n_err++;
            $display("FAIL busy_start_capture got %b want %b", bus.o_capture, in_w);
        end
        last_cap = in_w;
    endtask

    task automatic test_back_to_back();
        logic [CL-1:0] in1, in2, pat1, pat2;
        logic [3:0]    obs;
        logic [3:0]    exp;
        int            b;
        in1  = CL'($urandom);
        in2  = ~in1;
        pat1 = CL'($urandom);
        pat2 = ~pat1;
        b    = int'(CL) + 3;
        chain_in      = in1;
        bus.i_pattern = pat1;
        for (int c = 0; c <= 2 * b; c++) begin
            obs = ctrl_obs();
            exp = (c < b) ? exp_ctrl(c, pat1) : exp_ctrl(c - b, pat2);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL b2b_ctrl c=%0d got %b want %b", c, obs, exp);
            end
            if (c == b - 1 || c == 2 * b - 1) begin
                n_vec++;
                if (bus.o_capture !== ((c < b) ? in1 : in2)) begin
                    n_err++;
                    $display("FAIL b2b_capture c=%0d got %b want %b", c, bus.o_capture,
                             (c < b) ? in1 : in2);
                end
                n_vec++;
                if (chain_q !== ((c < b) ? pat1 : pat2)) begin
                    n_err++;
                    $display("FAIL b2b_chain_load c=%0d got %b want %b", c, chain_q,
                             (c < b) ? pat1 : pat2);
                end
            end
            bus.i_start = (c <= b);
            step();
            bus.i_start   = 1'b0;
            bus.i_pattern = pat2;
            chain_in      = (c + 1 <= 1) ? in1 : (c + 1 <= b + 1) ? in2 : CL'($urandom);
        end
        last_cap = in2;
    endtask

    task automatic test_reset_mid();
        logic [CL-1:0] pat;
        logic [3:0]    obs;
        logic [CL+4:0] all;
        do_scan(4'b0111, 4'b0001, 1'b0);
        pat           = 4'b1111;
        chain_in      = CL'($urandom);
        bus.i_pattern = pat;
        bus.i_start   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            bus.i_start = 1'b0;
        end
        obs = ctrl_obs();
        n_vec++;
        if (obs !== exp_ctrl(4, pat)) begin
            n_err++;
            $display("FAIL midreset_pre got %b want %b", obs, exp_ctrl(4, pat));
        end
        #2 rst_n = 1'b0;
        #1;
        all = {ctrl_obs(), bus.o_capture, bus.o_parity};
        n_vec++;
        if (all !== '0) begin
            n_err++;
            $display("FAIL midreset_async got %b want 0", all);
        end
        step();
        rst_n    = 1'b1;
        last_cap = '0;
        step();
        all = {ctrl_obs(), bus.o_capture, bus.o_parity};
        n_vec++;
        if (all !== '0) begin
            n_err++;
            $display("FAIL midreset_release got %b want 0", all);
        end
        do_scan(CL'($urandom), CL'($urandom), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_abort();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
